// File: rtl/dfr_output_buffer.sv
// Output buffer for DFR reservoir results. It stores 1/8/17 floats in a circular RAM and
// replays them in order on a valid/ready stream as IEEE-754 single-precision values.
module dfr_output_buffer #(
   parameter int ADDR_WIDTH = 13,
   parameter int DEPTH      = 8192,
   parameter int DATA_WIDTH = 26
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  overflow
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD
   } state_t;

   localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
   localparam logic [ADDR_WIDTH:0]   CNT_MAX = DEPTH;
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  out_valid_q, out_valid_d;
   logic [31:0]           out_data_q, out_data_d;
   logic                  overflow_q, overflow_d;

   logic                  full_w;
   logic                  wr_accept;
   logic                  pop;
   logic                  mem_we;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;

   // Exponent 0 flushes to a signed zero. Every other exponent, 255 included, passes through.
   function automatic logic [31:0] to_ieee(input logic [DATA_WIDTH-1:0] w);
      logic [31:0] r;
      if (w[24:17] == 8'd0) begin
         r = {w[25], 31'd0};
      end else begin
         r = {w[25], w[24:17], w[16:0], 6'd0};
      end
      return r;
   endfunction

   assign full_w = (count_q == CNT_MAX);

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      overflow_d  = overflow_q;
      rd_en       = 1'b0;
      rd_addr     = rd_ptr_q;

      // full is taken before this cycle's pop, so a write arriving while full is dropped.
      wr_accept = wr_en && !full_w;
      pop       = out_valid_q && out_ready;
      mem_we    = wr_accept && !clear;

      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (wr_en && full_w) begin
         overflow_d = 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      case ({wr_accept, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               rd_en   = 1'b1;
               rd_addr = rd_ptr_q;
               state_d = FETCH;
            end
         end
         FETCH: begin
            out_data_d  = to_ieee(rd_data_q);
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            // Only entries written before this edge are prefetched. This avoids reading a RAM word in the same cycle it is written.
            if (pop) begin
               out_valid_d = 1'b0;
               if (count_q > CNT_ONE) begin
                  rd_en   = 1'b1;
                  rd_addr = rd_ptr_d;
                  state_d = FETCH;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (clear) begin
         state_d     = IDLE;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
         overflow_d  = 1'b0;
         rd_en       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         overflow_q  <= overflow_d;
      end
   end

   // The RAM has no reset, so it can map onto block RAM with a registered read port.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_ptr_q] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign count     = count_q;
   assign full      = full_w;
   assign empty     = (count_q == '0);
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_dfr_output_buffer.sv
// Bench for dfr_output_buffer at DEPTH=4. It combines a conversion vector table, directed
// corner-case sequences and a random phase, all checked against a queue-based model.
module tb_dfr_output_buffer;

   localparam int AW = 2;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          clear;
   logic          wr_en;
   logic [25:0]   wr_data;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_data;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          overflow;

   int            compared = 0;
   int            mismatched = 0;
   logic [25:0]   model_q[$];
   logic          model_ovf = 1'b0;
   int            pop_count = 0;
   int            wait_cycles = 0;

   typedef struct {
      logic [25:0] wr;
      logic [31:0] exp_out;
   } vec_t;

   vec_t vecs[7];

   dfr_output_buffer #(.ADDR_WIDTH(AW), .DEPTH(D), .DATA_WIDTH(26)) dut (
      .clk(clk),
      .reset(reset),
      .clear(clear),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .count(count),
      .full(full),
      .empty(empty),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] refConvert(input logic [25:0] w);
      logic [31:0] s, e, m;
      s = 32'(w[25]);
      e = 32'(w[24:17]);
      m = 32'(w[16:0]);
      if (e == 0) return s * 32'h8000_0000;
      return s * 32'h8000_0000 + e * 32'h0080_0000 + m * 32'd64;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic wr, input logic [25:0] d, input logic rdy, input logic clr);
      logic        pre_valid;
      logic [31:0] pre_data;
      logic        pop;
      logic        acc;
      logic        full_pre;
      wr_en     = wr;
      wr_data   = d;
      out_ready = rdy;
      clear     = clr;
      pre_valid = out_valid;
      pre_data  = out_data;
      full_pre  = (model_q.size() >= D);
      pop       = pre_valid && rdy && !clr;
      acc       = wr && !clr && !full_pre;
      if (pop) begin
         checkOutput("pop_has_entry", 32'(model_q.size() > 0), 1);
         if (model_q.size() > 0) checkOutput("pop_data", pre_data, refConvert(model_q[0]));
      end
      @(posedge clk);
      #1;
      if (clr) begin
         model_q.delete();
         model_ovf   = 1'b0;
         wait_cycles = 0;
         checkOutput("clear_valid", 32'(out_valid), 0);
         checkOutput("clear_data", out_data, 0);
      end else begin
         if (wr && full_pre) model_ovf = 1'b1;
         if (pop && model_q.size() > 0) begin
            void'(model_q.pop_front());
            pop_count++;
         end
         if (acc) model_q.push_back(d);
         if (pre_valid && !rdy) begin
            checkOutput("hold_valid", 32'(out_valid), 1);
            checkOutput("hold_data", out_data, pre_data);
         end
      end
      checkOutput("count", 32'(count), 32'(model_q.size()));
      checkOutput("full", 32'(full), 32'(model_q.size() == D));
      checkOutput("empty", 32'(empty), 32'(model_q.size() == 0));
      checkOutput("overflow", 32'(overflow), 32'(model_ovf));
      if (model_q.size() > 0 && !out_valid) wait_cycles++;
      else wait_cycles = 0;
      checkOutput("latency_bound", 32'(wait_cycles <= 3), 1);
      if (out_valid) checkOutput("valid_has_entry", 32'(model_q.size() > 0), 1);
   endtask

   initial begin
      int start_pops;
      int written;
      int last_pop_cycle;
      int prev_pops;
      logic [25:0] b0;
      logic [25:0] rnd;

      vecs[0] = '{{1'b0, 8'd127, 17'h10000}, 32'h3FC0_0000};
      vecs[1] = '{{1'b1, 8'd0,   17'h1FFFF}, 32'h8000_0000};
      vecs[2] = '{{1'b0, 8'd128, 17'h00000}, 32'h4000_0000};
      vecs[3] = '{{1'b1, 8'd255, 17'h1FFFF}, 32'hFFFF_FFC0};
      vecs[4] = '{{1'b0, 8'd255, 17'h00000}, 32'h7F80_0000};
      vecs[5] = '{{1'b1, 8'd1,   17'h00001}, 32'h8080_0040};
      vecs[6] = '{{1'b0, 8'd0,   17'h00000}, 32'h0000_0000};

      reset     = 1'b1;
      clear     = 1'b0;
      wr_en     = 1'b0;
      wr_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("rst_valid", 32'(out_valid), 0);
      checkOutput("rst_data", out_data, 0);
      checkOutput("rst_count", 32'(count), 0);
      checkOutput("rst_empty", 32'(empty), 1);
      checkOutput("rst_full", 32'(full), 0);
      checkOutput("rst_overflow", 32'(overflow), 0);

      $display("[TB] conversion table and 2-cycle latency");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, vecs[i].wr, 1'b0, 1'b0);
         checkOutput("lat_edge_n", 32'(out_valid), 0);
         applyStimulus(1'b0, 26'd0, 1'b0, 1'b0);
         checkOutput("lat_edge_n1", 32'(out_valid), 0);
         applyStimulus(1'b0, 26'd0, 1'b0, 1'b0);
         checkOutput("lat_edge_n2", 32'(out_valid), 1);
         checkOutput("vec_data", out_data, vecs[i].exp_out);
         applyStimulus(1'b0, 26'd0, 1'b1, 1'b0);
         checkOutput("vec_empty_after_pop", 32'(empty), 1);
      end

      $display("[TB] backpressure and drain rate");
      b0 = 26'($urandom);
      applyStimulus(1'b1, b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 26'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b1, 26'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b0, 26'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 26'd0, 1'b0, 1'b0);
      checkOutput("bp_valid", 32'(out_valid), 1);
      checkOutput("bp_first_data", out_data, refConvert(b0));
      checkOutput("bp_count", 32'(count), 3);
      start_pops = pop_count;
      last_pop_cycle = -1;
      for (int c = 0; c < 20 && model_q.size() > 0; c++) begin
         prev_pops = pop_count;
         applyStimulus(1'b0, 26'd0, 1'b1, 1'b0);
         if (pop_count != prev_pops) begin
            if (last_pop_cycle >= 0) checkOutput("drain_spacing", 32'(c - last_pop_cycle), 2);
            last_pop_cycle = c;
         end
      end
      checkOutput("bp_drained", 32'(pop_count - start_pops), 3);

      $display("[TB] full, overflow, write while full with pop");
      applyStimulus(1'b0, 26'd0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 26'($urandom), 1'b0, 1'b0);
      checkOutput("ovf_full", 32'(full), 1);
      checkOutput("ovf_count", 32'(count), 4);
      checkOutput("ovf_flag", 32'(overflow), 1);
      applyStimulus(1'b0, 26'd0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 26'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b0, 26'd0, 1'b0, 1'b0);
      checkOutput("full_ready", 32'(out_valid), 1);
      start_pops = pop_count;
      applyStimulus(1'b1, 26'h3ABCDEF, 1'b1, 1'b0);
      checkOutput("full_wr_pop_count", 32'(count), 3);
      checkOutput("full_wr_pop_ovf", 32'(overflow), 1);
      for (int c = 0; c < 20 && model_q.size() > 0; c++) applyStimulus(1'b0, 26'd0, 1'b1, 1'b0);
      checkOutput("full_drained", 32'(pop_count - start_pops), 4);

      $display("[TB] simultaneous write and pop");
      applyStimulus(1'b0, 26'd0, 1'b0, 1'b1);
      applyStimulus(1'b1, 26'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b1, 26'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b0, 26'd0, 1'b0, 1'b0);
      checkOutput("sim_pre_count", 32'(count), 2);
      applyStimulus(1'b1, 26'($urandom), 1'b1, 1'b0);
      checkOutput("sim_count_same", 32'(count), 2);
      for (int c = 0; c < 20 && model_q.size() > 0; c++) applyStimulus(1'b0, 26'd0, 1'b1, 1'b0);

      $display("[TB] wrap-around stream of 10");
      start_pops = pop_count;
      written = 0;
      for (int c = 0; c < 200 && (pop_count - start_pops) < 10; c++) begin
         if (written < 10 && model_q.size() < D && $urandom_range(0, 3) != 0) begin
            applyStimulus(1'b1, 26'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            written++;
         end else begin
            applyStimulus(1'b0, 26'd0, 1'($urandom_range(0, 1)), 1'b0);
         end
      end
      checkOutput("wrap_popped", 32'(pop_count - start_pops), 10);

      $display("[TB] clear mid-stream");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 26'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b1, 26'($urandom), 1'b1, 1'b1);
      checkOutput("clr_count", 32'(count), 0);
      checkOutput("clr_overflow", 32'(overflow), 0);
      checkOutput("clr_empty", 32'(empty), 1);
      applyStimulus(1'b0, 26'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 26'd0, 1'b0, 1'b0);
      checkOutput("clr_no_ghost", 32'(out_valid), 0);

      $display("[TB] async reset during HOLD");
      applyStimulus(1'b1, 26'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b1, 26'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b0, 26'd0, 1'b0, 1'b0);
      checkOutput("hold_before_reset", 32'(out_valid), 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_valid", 32'(out_valid), 0);
      checkOutput("async_rst_count", 32'(count), 0);
      checkOutput("async_rst_data", out_data, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_q.delete();
      model_ovf   = 1'b0;
      wait_cycles = 0;
      rnd = {1'b0, 8'd130, 17'h0ABCD};
      applyStimulus(1'b1, rnd, 1'b0, 1'b0);
      applyStimulus(1'b0, 26'd0, 1'b0, 1'b0);
      checkOutput("post_rst_lat_n1", 32'(out_valid), 0);
      applyStimulus(1'b0, 26'd0, 1'b0, 1'b0);
      checkOutput("post_rst_lat_n2", 32'(out_valid), 1);
      checkOutput("post_rst_data", out_data, refConvert(rnd));

      $display("[TB] random phase");
      for (int c = 0; c < 600; c++) begin
         applyStimulus(1'($urandom_range(0, 1)), 26'($urandom), 1'($urandom_range(0, 2) != 0),
                       1'($urandom_range(0, 63) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
